// File: rtl/seg7_frame_decoder_if.sv
// Bus bundle between a multiplexed 7-segment driver and its frame decoder.
// master drives the segment bus, slave decodes it back into frames.
interface seg7_frame_decoder_if #(
    parameter int DIGITS = 6
);
    logic [6:0]          seg;
    logic [DIGITS-1:0]   digit_sel;
    logic                clear_err;
    logic [4*DIGITS-1:0] frame;
    logic                frame_valid;
    logic                bad_glyph;
    logic                bad_sel;

    modport master (
        output seg, digit_sel, clear_err,
        input  frame, frame_valid, bad_glyph, bad_sel
    );

    modport slave (
        input  seg, digit_sel, clear_err,
        output frame, frame_valid, bad_glyph, bad_sel
    );
endinterface

// File: rtl/seg7_frame_decoder.sv
// Receive side of the lab display path: recovers nibble frames from a
// time-multiplexed active-low 7-segment bus, HEX5 at MSB, HEX0 at LSB.
module seg7_frame_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int DIGITS        = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    seg7_frame_decoder_if.slave  bus
);
    localparam int FW = 4 * DIGITS;
    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
    localparam logic [DIGITS-1:0] D0 = DIGITS'(1);

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    state_t              state, state_nxt;
    logic [6:0]          smp_seg, prv_seg;
    logic [DIGITS-1:0]   smp_sel, prv_sel;
    logic [7:0]          cnt, cnt_nxt;
    logic                same, accept;
    logic                legal;
    logic [3:0]          nib;
    logic                sel_zero, sel_one, take, is_d0;
    logic                glyph_err, sel_err;
    logic [DIGITS-1:0]   mask, mask_nxt;
    logic [FW-1:0]       shadow, shadow_nxt, frame_q;
    logic                full;
    logic                bad_glyph_q, bad_sel_q;

    // Input register plus the previous sample, and the stability counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            smp_seg <= '0;
            smp_sel <= '0;
            prv_seg <= '0;
            prv_sel <= '0;
            cnt     <= '0;
        end else begin
            smp_seg <= bus.seg;
            smp_sel <= bus.digit_sel;
            prv_seg <= smp_seg;
            prv_sel <= smp_sel;
            cnt     <= cnt_nxt;
        end
    end

    // Saturating run counter; acceptance fires only on the cycle it reaches the limit.
    always_comb begin
        same    = ({smp_sel, smp_seg} == {prv_sel, prv_seg});
        cnt_nxt = 8'd1;
        if (same) cnt_nxt = (cnt == STABLE) ? cnt : cnt + 8'd1;
        accept  = (cnt_nxt == STABLE) && !(same && (cnt == STABLE));
    end

    // Glyph lookup and classification of the accepted sample.
    always_comb begin
        legal = 1'b1;
        nib   = 4'h0;
        case (smp_seg)
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h18: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: legal = 1'b0;
        endcase
        sel_zero  = (smp_sel == '0);
        sel_one   = !sel_zero && ((smp_sel & (smp_sel - D0)) == '0);
        is_d0     = smp_sel[0];
        take      = accept && sel_one && legal;
        glyph_err = accept && sel_one && !legal;
        sel_err   = accept && !sel_zero && !sel_one;
    end

    // Shadow slot writes and seen-mask bookkeeping for the current state.
    always_comb begin
        mask_nxt   = mask;
        shadow_nxt = shadow;
        unique case (state)
            IDLE: begin
                if (take && is_d0) begin
                    mask_nxt         = D0;
                    shadow_nxt[3:0]  = nib;
                end
            end
            COLLECT: begin
                if (take) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (smp_sel[i]) shadow_nxt[4*i +: 4] = nib;
                    end
                    mask_nxt = is_d0 ? D0 : (mask | smp_sel);
                end
            end
            EMIT: mask_nxt = '0;
            default: mask_nxt = '0;
        endcase
        full = &mask_nxt;
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: align on digit 0, emit once every digit has been seen.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (take && is_d0) state_nxt = full ? EMIT : COLLECT;
            COLLECT: if (full) state_nxt = EMIT;
            EMIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: the valid pulse is the single EMIT cycle.
    always_comb begin
        bus.frame_valid = (state == EMIT);
        bus.frame       = frame_q;
        bus.bad_glyph   = bad_glyph_q;
        bus.bad_sel     = bad_sel_q;
    end

    // Datapath: mask, shadow, frame load on entry to EMIT, sticky error flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mask        <= '0;
            shadow      <= '0;
            frame_q     <= '0;
            bad_glyph_q <= 1'b0;
            bad_sel_q   <= 1'b0;
        end else begin
            mask   <= mask_nxt;
            shadow <= shadow_nxt;
            if (state_nxt == EMIT) frame_q <= shadow_nxt;
            if (glyph_err)          bad_glyph_q <= 1'b1;
            else if (bus.clear_err) bad_glyph_q <= 1'b0;
            if (sel_err)            bad_sel_q <= 1'b1;
            else if (bus.clear_err) bad_sel_q <= 1'b0;
        end
    end
endmodule

// File: doc/seg7_frame_decoder.md
Name: seg7_frame_decoder

Overview:
- Receive end of the lab display path: observes a time-multiplexed, active-low 7-segment bus driving six digits and turns it back into numeric data.
- Decodes each stable segment pattern back to its 4-bit nibble and assembles a 24-bit frame, HEX5 at the MSB and HEX0 at the LSB.
- Emits the frame with a one-cycle valid pulse.
- Used on the bench and on-board to self-check ALU result displays without reading LEDs by eye.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples of {digit_sel, seg} required before a digit is accepted (range 1..255).
- DIGITS, 6: number of multiplexed digits; the frame width is 4*DIGITS.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- seg  in  7  active-low segment pattern; bit 0 = segment a … bit 6 = segment g.
- digit_sel  in  DIGITS  one-hot strobe identifying which digit seg belongs to.
- frame  out  4*DIGITS  last completed frame; digit i occupies bits [4i+3:4i].
- frame_valid  out  1  one-cycle pulse when frame updates.
- bad_glyph  out  1  sticky flag: an accepted sample did not match any legal glyph.
- bad_sel  out  1  sticky flag: a stable digit_sel was non-zero and not one-hot.
- clear_err  in  1  synchronous clear of bad_glyph and bad_sel.

Behaviour:
- Reset (asynchronous, immediate):
  - frame=0, frame_valid=0, bad_glyph=0, bad_sel=0.
  - Stability counter=0, seen-mask=0, state=IDLE.
- Glyph table (seg hex → nibble): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 18→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F. All other patterns are illegal.
- Sampling:
  - Inputs are registered once on entry (1-cycle delay).
  - The registered sample is compared with the previous registered sample.
  - Equal: the counter increments, saturating at STABLE_CYCLES.
  - Different: the counter loads 1.
- Acceptance: occurs on the cycle the counter reaches exactly STABLE_CYCLES. There is one acceptance per stable run; holding the inputs longer does not re-accept.
- On acceptance:
  - digit_sel == 0: ignored (display blanking gap). Nothing changes.
  - digit_sel not one-hot: bad_sel←1; the sample is discarded.
  - Illegal glyph: bad_glyph←1; the digit slot is not written and the seen-bit is not set.
  - Otherwise: the nibble is written to shadow slot i and seen-mask[i]←1.
- State machine:
  - IDLE: waits for the first acceptance of digit 0. This enforces frame alignment. Acceptances for any other digit are ignored in IDLE.
  - From IDLE → COLLECT: digit 0 is captured as above.
  - In COLLECT, if digit 0 is accepted again before the mask is full:
    - The shadow slots for other digits are kept, the mask restarts as 000001, and the state stays COLLECT.
    - No frame is emitted.
  - COLLECT → EMIT when seen-mask becomes all ones.
  - EMIT lasts one cycle: frame←shadow, frame_valid=1, mask←0, then → IDLE.
  - A repeat acceptance of a non-zero digit already seen overwrites its shadow slot. This is not an error.
- Latency: frame_valid asserts 2 cycles after the cycle in which the last digit's STABLE_CYCLES-th matching sample is registered. Count as 1 cycle for acceptance plus 1 cycle for EMIT, plus the input register.
- Error flags:
  - Sticky until clear_err or reset.
  - If clear_err coincides with a new error event, the new error wins and the flag stays 1.
  - Errors never block frame assembly for other digits.
- Frame output holds its value between frame_valid pulses.
- Reset asserted mid-frame discards partial data. The next frame must start again from digit 0.

Test Plan:
- Reset → all outputs 0. Then scan digits 0..5 with glyphs 79,24,30,19,12,02, each held 4 cycles → one frame_valid pulse, frame=24'h654321, no error flags.
- STABLE_CYCLES=4, digit 2 held only 3 cycles within an otherwise valid scan → no frame_valid. A subsequent complete scan with digit 2 = 0E → frame[11:8]=F.
- Digit 3 driven with seg=7'h7F (blank/illegal) → bad_glyph=1 and no frame. clear_err pulse → bad_glyph=0.
- digit_sel=6'b000110 held stable → bad_sel=1. digit_sel=0 gaps between digits → ignored, and the frame still completes.
- Scan starts at digit 3 → ignored until digit 0. Digit 0 repeated mid-scan → mask restarts, and exactly one frame is emitted after digits 1..5 follow.
- Reset asserted after digits 0..3 → outputs return to 0 asynchronously. The next full scan 40,40,40,40,40,18 yields frame=24'h900000.
